scan_decoder: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with enable.
- Adds an auto-scan mode: an internal counter steps the decoded index through all 2^N outputs, holding each output for a programmable dwell period.
- Intended for multiplexed display digit drive and strobe sequencing.
- Same decoder function as the team's combinational 3-to-8 decoder, generalised in width, made synchronous, and given scan behaviour.

---
 rtl/scan_decoder.sv | 88 ++++++++
 tb/tb_scan_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode that
// steps the decoded index through every output, holding each for dwell+1 cycles.
module scan_decoder #(
    parameter int N_SEL      = 3,
    parameter int DIV_W      = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  En,
    input  logic                  mode,
    input  logic [N_SEL-1:0]      X,
    input  logic [DIV_W-1:0]      dwell,
    output logic [2**N_SEL-1:0]   O,
    output logic [N_SEL-1:0]      idx,
    output logic                  wrap
);

    localparam int unsigned W = 2**N_SEL;
    localparam logic [W-1:0] O_OFF = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [N_SEL-1:0]   idx_q, idx_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic [W-1:0]       o_q, o_d;
    logic [W-1:0]       hot;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        hot     = '0;

        if (!En) begin
            state_d = IDLE;
        end else if (!mode) begin
            state_d = DIRECT;
            idx_d   = X;
            cnt_d   = '0;
            hot[X]  = 1'b1;
        end else begin
            state_d = SCAN;
            // The edge entering SCAN only re-asserts O; stepping begins on the
            // next edge, so a resumed scan neither loses nor repeats an advance.
            if (state_q == SCAN) begin
                if (cnt_q >= dwell) begin
                    cnt_d  = '0;
                    idx_d  = idx_q + 1'b1;
                    wrap_d = (idx_q == '1);
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            hot[idx_d] = 1'b1;
        end

        o_d = (ACTIVE_LOW != 0) ? ~hot : hot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            o_q     <= O_OFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            o_q     <= o_d;
        end
    end

    assign O    = o_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed scenarios plus random stimulus,
// checked against a cycle-level arithmetic model of the decoder and scanner.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst, En, mode;
    logic [2:0] X;
    logic [7:0] dwell;
    logic [7:0] O_h, O_l;
    logic [2:0] idx_h, idx_l;
    logic       wrap_h, wrap_l;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int m_idx  = 0;
    int m_cnt  = 0;
    bit m_on   = 0;
    bit m_scan = 0;
    bit m_wrap = 0;

    always #5 clk = ~clk;

    scan_decoder #(.N_SEL(3), .DIV_W(8), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst(rst), .En(En), .mode(mode), .X(X), .dwell(dwell),
        .O(O_h), .idx(idx_h), .wrap(wrap_h)
    );

    scan_decoder #(.N_SEL(3), .DIV_W(8), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .rst(rst), .En(En), .mode(mode), .X(X), .dwell(dwell),
        .O(O_l), .idx(idx_l), .wrap(wrap_l)
    );

    function automatic logic [7:0] exp_o();
        logic [7:0] v;
        v = 8'h00;
        if (m_on) v = 8'(1 << m_idx);
        return v;
    endfunction

    // one rising edge: advance the model with the inputs that edge samples
    task automatic tick();
        bit r, e, md;
        int x, d;
        r = rst; e = En; md = mode; x = int'(X); d = int'(dwell);
        @(posedge clk);
        if (r) begin
            m_idx = 0; m_cnt = 0; m_on = 0; m_scan = 0; m_wrap = 0;
        end else if (!e) begin
            m_on = 0; m_scan = 0; m_wrap = 0;
        end else if (!md) begin
            m_idx = x; m_cnt = 0; m_on = 1; m_scan = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (m_scan) begin
                if (m_cnt >= d) begin
                    m_cnt = 0;
                    m_wrap = (m_idx == 7);
                    m_idx = (m_idx + 1) % 8;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_scan = 1; m_on = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; En = 1'b1; mode = 1'b0; X = 3'd3; dwell = 8'd0;
        tick(); tick();
        n_checks++; if (O_h !== 8'h00) begin n_err++; $display("FAIL reset_O_h got %h want 00", O_h); end
        n_checks++; if (O_l !== 8'hFF) begin n_err++; $display("FAIL reset_O_l got %h want ff", O_l); end
        n_checks++; if (idx_h !== 3'd0 || idx_l !== 3'd0) begin n_err++; $display("FAIL reset_idx got %0d/%0d want 0", idx_h, idx_l); end
        n_checks++; if (wrap_h !== 1'b0 || wrap_l !== 1'b0) begin n_err++; $display("FAIL reset_wrap got %b/%b want 0", wrap_h, wrap_l); end
    endtask

    task automatic test_direct();
        logic [7:0] want;
        rst = 1'b0; En = 1'b1; mode = 1'b0;
        for (int x = 0; x < 8; x++) begin
            X = 3'(x);
            tick();
            want = 8'(1 << x);
            n_checks++; if (O_h !== want || O_h !== exp_o()) begin n_err++; $display("FAIL direct_O x=%0d got %h want %h", x, O_h, want); end
            n_checks++; if (O_l !== ~want) begin n_err++; $display("FAIL direct_O_l x=%0d got %h want %h", x, O_l, ~want); end
            n_checks++; if (idx_h !== 3'(x)) begin n_err++; $display("FAIL direct_idx got %0d want %0d", idx_h, x); end
        end
    endtask

    task automatic test_enable_gating();
        X = 3'd5; mode = 1'b0; En = 1'b1;
        tick();
        n_checks++; if (O_h !== 8'h20) begin n_err++; $display("FAIL gate_on got %h want 20", O_h); end
        En = 1'b0;
        tick();
        n_checks++; if (O_h !== 8'h00 || O_l !== 8'hFF) begin n_err++; $display("FAIL gate_off got %h/%h want 00/ff", O_h, O_l); end
        n_checks++; if (idx_h !== 3'd5) begin n_err++; $display("FAIL gate_idx_hold got %0d want 5", idx_h); end
        En = 1'b1;
        tick();
        n_checks++; if (O_h !== 8'h20) begin n_err++; $display("FAIL gate_reon got %h want 20", O_h); end
    endtask

    task automatic test_scan_dwell2();
        int wraps, wrap_at;
        X = 3'd0; mode = 1'b0; En = 1'b1;
        tick();
        mode = 1'b1; dwell = 8'd2;
        wraps = 0; wrap_at = -1;
        for (int t = 0; t < 27; t++) begin
            tick();
            if (wrap_h === 1'b1) begin wraps++; wrap_at = t; end
            n_checks++; if (idx_h !== 3'((t / 3) % 8)) begin n_err++; $display("FAIL scan2_idx t=%0d got %0d want %0d", t, idx_h, (t / 3) % 8); end
            n_checks++; if (O_h !== exp_o() || O_l !== ~exp_o()) begin n_err++; $display("FAIL scan2_O t=%0d got %h/%h want %h", t, O_h, O_l, exp_o()); end
            n_checks++; if (wrap_h !== m_wrap || wrap_l !== m_wrap) begin n_err++; $display("FAIL scan2_wrap t=%0d got %b want %b", t, wrap_h, m_wrap); end
        end
        n_checks++; if (wraps != 1 || wrap_at != 24) begin n_err++; $display("FAIL scan2_wrap_count got %0d at %0d want 1 at 24", wraps, wrap_at); end
    endtask

    task automatic test_freeze_resume();
        bit found;
        mode = 1'b1; En = 1'b1; dwell = 8'd0; found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            tick();
            n_checks++; if (idx_h !== 3'(m_idx) || O_h !== exp_o()) begin n_err++; $display("FAIL frz_run got %0d/%h want %0d/%h", idx_h, O_h, m_idx, exp_o()); end
            if (idx_h === 3'd4) found = 1;
        end
        n_checks++; if (!found) begin n_err++; $display("FAIL frz_reach4 got idx %0d want 4 within 40 cycles", idx_h); end
        En = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_checks++; if (O_h !== 8'h00 || idx_h !== 3'd4) begin n_err++; $display("FAIL frz_hold got %h idx %0d want 00 idx 4", O_h, idx_h); end
        end
        En = 1'b1;
        tick();
        n_checks++; if (O_h !== 8'h10 || O_h !== exp_o()) begin n_err++; $display("FAIL frz_resume1 got %h want 10", O_h); end
        tick();
        n_checks++; if (O_h !== 8'h20 || O_l !== 8'hDF) begin n_err++; $display("FAIL frz_resume2 got %h/%h want 20/df", O_h, O_l); end
    endtask

    task automatic test_live_dwell();
        int start;
        En = 1'b1; mode = 1'b0; X = 3'd2; dwell = 8'd200;
        tick();
        mode = 1'b1;
        tick();
        for (int t = 0; t < 150; t++) tick();
        n_checks++; if (idx_h !== 3'd2 || m_cnt != 150) begin n_err++; $display("FAIL live_pre got idx %0d cnt %0d want 2/150", idx_h, m_cnt); end
        dwell = 8'd10;
        tick();
        n_checks++; if (idx_h !== 3'd3 || O_h !== 8'h08) begin n_err++; $display("FAIL live_force got %0d/%h want 3/08", idx_h, O_h); end
        start = 3;
        for (int t = 1; t <= 22; t++) begin
            tick();
            n_checks++; if (idx_h !== 3'(start + t / 11)) begin n_err++; $display("FAIL live_period t=%0d got %0d want %0d", t, idx_h, start + t / 11); end
        end
    endtask

    task automatic test_midscan_reset();
        bit found;
        mode = 1'b1; En = 1'b1; dwell = 8'd0; found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            tick();
            if (idx_l === 3'd6) found = 1;
        end
        n_checks++; if (!found || O_l !== 8'hBF) begin n_err++; $display("FAIL mrst_reach6 got idx %0d O %h want 6/bf", idx_l, O_l); end
        rst = 1'b1;
        tick();
        n_checks++; if (O_l !== 8'hFF || O_h !== 8'h00) begin n_err++; $display("FAIL mrst_O got %h/%h want ff/00", O_l, O_h); end
        n_checks++; if (idx_l !== 3'd0 || wrap_l !== 1'b0) begin n_err++; $display("FAIL mrst_idx got %0d wrap %b want 0/0", idx_l, wrap_l); end
        rst = 1'b0;
        tick();
        n_checks++; if (O_l !== 8'hFE || O_h !== 8'h01) begin n_err++; $display("FAIL mrst_release got %h/%h want fe/01", O_l, O_h); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            rst   = ($urandom_range(0, 59) == 0);
            En    = ($urandom_range(0, 7) != 0);
            mode  = ($urandom_range(0, 3) != 0);
            X     = 3'($urandom_range(0, 7));
            dwell = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            tick();
            n_checks++; if (O_h !== exp_o() || O_l !== ~exp_o()) begin n_err++; $display("FAIL rnd_O t=%0d got %h/%h want %h", t, O_h, O_l, exp_o()); end
            n_checks++; if (idx_h !== 3'(m_idx) || idx_l !== 3'(m_idx)) begin n_err++; $display("FAIL rnd_idx t=%0d got %0d want %0d", t, idx_h, m_idx); end
            n_checks++; if (wrap_h !== m_wrap || wrap_l !== m_wrap) begin n_err++; $display("FAIL rnd_wrap t=%0d got %b want %b", t, wrap_h, m_wrap); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_direct();
        test_enable_gating();
        test_scan_dwell2();
        test_freeze_resume();
        test_live_dwell();
        test_midscan_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
